// File: rtl/backend_multi_channel_arbiter_pkg.sv
// Shared types and defaults for the multi-channel backend arbiter.
// Widths fall back to local defaults when the controller macros are absent.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

package backend_arb_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int CH_W_DEF      = $clog2(NUM_CH_DEF);
  localparam int CMD_BITS_DEF  = `FRONTEND_CMD_BITS;
  localparam int DATA_BITS_DEF = `DQ_BITS * 8;
  localparam int DEPTH_DEF     = 8;

  localparam int RD_FLAG_POS_DEF = 0;

  localparam int ERR_WR_NO_OWNER = 0;
  localparam int ERR_RD_NO_OWNER = 1;

  typedef logic [CH_W_DEF-1:0] ch_id_t;

endpackage

// File: rtl/backend_multi_channel_arbiter_if.sv
// Frontend-channel and backend-controller signal bundle.
// slave is the arbiter's view, master the surrounding logic's.
interface backend_multi_channel_arbiter_if
  import backend_arb_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CMD_BITS  = CMD_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic [NUM_CH-1:0]           i_ch_cmd_valid;
  logic [NUM_CH*CMD_BITS-1:0]  i_ch_cmd;
  logic [NUM_CH-1:0]           o_ch_cmd_ready;
  logic [NUM_CH*DATA_BITS-1:0] i_ch_wdata;
  logic [NUM_CH-1:0]           o_ch_wdata_ren;
  logic [DATA_BITS-1:0]        o_ch_rdata;
  logic [NUM_CH-1:0]           o_ch_rdata_valid;
  logic [NUM_CH-1:0]           i_ch_rdata_ready;

  logic                        o_frontend_command_valid;
  logic [CMD_BITS-1:0]         o_frontend_command;
  logic                        i_backend_controller_ready;
  logic [DATA_BITS-1:0]        o_frontend_write_data;
  logic                        i_backend_controller_ren;
  logic [DATA_BITS-1:0]        i_backend_read_data;
  logic                        i_backend_read_data_valid;
  logic                        o_frontend_controller_ready;
  logic                        o_backend_controller_stall;
  logic [1:0]                  o_err;

  modport slave (
    input  i_ch_cmd_valid, i_ch_cmd, i_ch_wdata, i_ch_rdata_ready,
    input  i_backend_controller_ready, i_backend_controller_ren,
    input  i_backend_read_data, i_backend_read_data_valid,
    output o_ch_cmd_ready, o_ch_wdata_ren, o_ch_rdata, o_ch_rdata_valid,
    output o_frontend_command_valid, o_frontend_command,
    output o_frontend_write_data, o_frontend_controller_ready,
    output o_backend_controller_stall, o_err
  );

  modport master (
    output i_ch_cmd_valid, i_ch_cmd, i_ch_wdata, i_ch_rdata_ready,
    output i_backend_controller_ready, i_backend_controller_ren,
    output i_backend_read_data, i_backend_read_data_valid,
    input  o_ch_cmd_ready, o_ch_wdata_ren, o_ch_rdata, o_ch_rdata_valid,
    input  o_frontend_command_valid, o_frontend_command,
    input  o_frontend_write_data, o_frontend_controller_ready,
    input  o_backend_controller_stall, o_err
  );

endinterface

// File: rtl/backend_multi_channel_arbiter_owner_id_fifo.sv
// Small FIFO of channel IDs recording backend issue order.
// Full ignores a same-cycle pop so a push never races a drain.
module owner_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/backend_multi_channel_arbiter.sv
// Round-robin N-channel front end for the backend controller; routes
// write-data pulls and read returns back to the issuing channel.
module backend_multi_channel_arbiter
  import backend_arb_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CMD_BITS    = CMD_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int RD_FLAG_POS = RD_FLAG_POS_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic clk,
  input  logic power_on_rst_n,
  backend_multi_channel_arbiter_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int CW1  = CH_W + 1;

  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic                 cr_valid_q, cr_valid_d;
  logic [CMD_BITS-1:0]  cr_cmd_q, cr_cmd_d;
  logic                 or_valid_q, or_valid_d;
  logic [DATA_BITS-1:0] or_data_q, or_data_d;
  logic [CH_W-1:0]      or_owner_q, or_owner_d;
  logic [1:0]           err_q, err_d;

  logic                 rd_full, rd_empty, wr_full, wr_empty;
  logic [CH_W-1:0]      rd_head, wr_head;
  logic [NUM_CH-1:0]    elig, gnt, wren, rdv;
  logic [CH_W:0]        idx;
  logic [CH_W-1:0]      gnt_id;
  logic [CMD_BITS-1:0]  gnt_cmd;
  logic                 any_gnt, cr_load;
  logic                 rd_push, wr_push, rd_pop, wr_pop, rd_ok;

  // Reset gates eligibility so no grant leaks out while held in reset.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = power_on_rst_n && bus.i_ch_cmd_valid[c] &&
                (bus.i_ch_cmd[c*CMD_BITS + RD_FLAG_POS] ?
                 !rd_full : !wr_full);
    end
  end

  always_comb begin
    cr_load = !cr_valid_q || bus.i_backend_controller_ready;
    any_gnt = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_q} + CW1'(i);
      if (idx >= CW1'(NUM_CH)) begin
        idx = idx - CW1'(NUM_CH);
      end
      if (cr_load && !any_gnt && elig[idx[CH_W-1:0]]) begin
        any_gnt = 1'b1;
        gnt_id  = idx[CH_W-1:0];
      end
    end
    gnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gnt[c] = any_gnt && (gnt_id == CH_W'(c));
    end
    gnt_cmd = bus.i_ch_cmd[gnt_id*CMD_BITS +: CMD_BITS];
    rd_push = any_gnt && gnt_cmd[RD_FLAG_POS];
    wr_push = any_gnt && !gnt_cmd[RD_FLAG_POS];
  end

  always_comb begin
    ptr_d      = ptr_q;
    cr_valid_d = cr_valid_q;
    cr_cmd_d   = cr_cmd_q;
    if (any_gnt) begin
      ptr_d = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
    end
    if (cr_load) begin
      cr_valid_d = any_gnt;
      if (any_gnt) begin
        cr_cmd_d = gnt_cmd;
      end
    end
  end

  always_comb begin
    wr_pop = bus.i_backend_controller_ren && !wr_empty;
    wren   = '0;
    rdv    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wren[c] = wr_pop && (wr_head == CH_W'(c));
      rdv[c]  = or_valid_q && (or_owner_q == CH_W'(c));
    end
  end

  always_comb begin
    rd_ok      = !or_valid_q || bus.i_ch_rdata_ready[or_owner_q];
    rd_pop     = bus.i_backend_read_data_valid && rd_ok && !rd_empty;
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_owner_d = or_owner_q;
    if (rd_pop) begin
      or_valid_d = 1'b1;
      or_data_d  = bus.i_backend_read_data;
      or_owner_d = rd_head;
    end else if (or_valid_q && bus.i_ch_rdata_ready[or_owner_q]) begin
      or_valid_d = 1'b0;
    end
    err_d = err_q;
    if (bus.i_backend_controller_ren && wr_empty) begin
      err_d[ERR_WR_NO_OWNER] = 1'b1;
    end
    if (bus.i_backend_read_data_valid && rd_empty) begin
      err_d[ERR_RD_NO_OWNER] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      ptr_q      <= '0;
      cr_valid_q <= 1'b0;
      cr_cmd_q   <= '0;
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_owner_q <= '0;
      err_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cr_valid_q <= cr_valid_d;
      cr_cmd_q   <= cr_cmd_d;
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_owner_q <= or_owner_d;
      err_q      <= err_d;
    end
  end

  owner_id_fifo #(.W(CH_W), .DEPTH(DEPTH)) u_rd_owner (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (rd_push),
    .din   (gnt_id),
    .pop   (rd_pop),
    .full  (rd_full),
    .empty (rd_empty),
    .head  (rd_head)
  );

  owner_id_fifo #(.W(CH_W), .DEPTH(DEPTH)) u_wr_owner (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (wr_push),
    .din   (gnt_id),
    .pop   (wr_pop),
    .full  (wr_full),
    .empty (wr_empty),
    .head  (wr_head)
  );

  assign bus.o_ch_cmd_ready              = gnt;
  assign bus.o_frontend_command_valid    = cr_valid_q;
  assign bus.o_frontend_command          = cr_cmd_q;
  assign bus.o_ch_wdata_ren              = wren;
  assign bus.o_frontend_write_data       = wr_empty ? '0 :
    bus.i_ch_wdata[wr_head*DATA_BITS +: DATA_BITS];
  assign bus.o_ch_rdata                  = or_data_q;
  assign bus.o_ch_rdata_valid            = rdv;
  assign bus.o_frontend_controller_ready = rd_ok;
  assign bus.o_backend_controller_stall  = !rd_ok;
  assign bus.o_err                       = err_q;

endmodule
